// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the pwm_bank block.
//   reg_sel_e : register offset within a channel's 4-word window
//   CTRL_*    : bit positions inside the CTRL register
package pwm_bank_pkg;

  typedef enum logic [1:0] {
    REG_PERIOD = 2'd0,
    REG_DUTY   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN  = 0;  // channel enable
  localparam int CTRL_INV = 1;  // output inversion (only while enabled)
  localparam int CTRL_RST = 2;  // one-shot counter restart, self-clearing

endpackage

// File: rtl/pwm_chan.sv
// One PWM generator channel.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wr_period/duty/ctrl : single-cycle write enables from the bus decoder
//   wr_data           : write data truncated to CNT_W bits
//   ctrl_bits         : low three bits of the write data (CTRL layout)
//   period_stage, duty_stage : staged (not yet active) settings, for readback
//   count             : live counter value
//   enable, invert    : current CTRL state
//   pwm               : registered PWM output
module pwm_chan
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic             wr_ctrl,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [2:0]       ctrl_bits,
  output logic [CNT_W-1:0] period_stage,
  output logic [CNT_W-1:0] duty_stage,
  output logic [CNT_W-1:0] count,
  output logic             enable,
  output logic             invert,
  output logic             pwm
);

  logic [CNT_W-1:0] period_stage_reg;
  logic [CNT_W-1:0] duty_stage_reg;
  logic [CNT_W-1:0] period_act_reg;
  logic [CNT_W-1:0] duty_act_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             enable_reg;
  logic             invert_reg;
  logic             pwm_reg;

  logic restart;
  logic wrap;
  logic load_act;
  logic raw;

  assign restart = wr_ctrl & ctrl_bits[CTRL_RST];
  assign wrap    = enable_reg & (count_reg == period_act_reg);
  // Active settings follow staging only at a period boundary so a running
  // waveform never sees a half-updated period; a stopped channel tracks
  // staging continuously so it starts with the latest values.
  assign load_act = wrap | ~enable_reg | restart;
  assign raw      = enable_reg & (count_reg < duty_act_reg);

  always_comb begin
    count_next = count_reg + 1'b1;
    if (restart || !enable_reg || wrap) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_stage_reg <= '0;
      duty_stage_reg   <= '0;
      period_act_reg   <= '0;
      duty_act_reg     <= '0;
      count_reg        <= '0;
      enable_reg       <= 1'b0;
      invert_reg       <= 1'b0;
      pwm_reg          <= 1'b0;
    end else begin
      if (wr_period) period_stage_reg <= wr_data;
      if (wr_duty)   duty_stage_reg   <= wr_data;
      if (wr_ctrl) begin
        enable_reg <= ctrl_bits[CTRL_EN];
        invert_reg <= ctrl_bits[CTRL_INV];
      end
      // Non-blocking load uses the pre-edge staging value, so a PERIOD/DUTY
      // write landing on a wrap edge waits for the following wrap.
      if (load_act) begin
        period_act_reg <= period_stage_reg;
        duty_act_reg   <= duty_stage_reg;
      end
      count_reg <= count_next;
      pwm_reg   <= raw ^ (invert_reg & enable_reg);
    end
  end

  assign period_stage = period_stage_reg;
  assign duty_stage   = duty_stage_reg;
  assign count        = count_reg;
  assign enable       = enable_reg;
  assign invert       = invert_reg;
  assign pwm          = pwm_reg;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank on the EBI slave bus.
// Each channel owns four words at BASE_ADDR + 4*ch: PERIOD, DUTY, CTRL, COUNT.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   ebi_addr       : EBI word address
//   ebi_data_in    : write data (low CNT_W bits used)
//   ebi_data_out   : registered read data, 0 when no read is active
//   ebi_wr, ebi_rd, ebi_cs : bus strobes, active-high
//   pwm_out        : one PWM output per channel
// Optional: define PWM_READBACK_EN to build the register read path; without
// it ebi_data_out is constant zero and ebi_rd is ignored.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int                NUM_CH    = 8,
  parameter int                CNT_W     = 16,
  parameter int                ADDR_W    = 21,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 21'h000100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ebi_addr,
  input  logic [15:0]       ebi_data_in,
  output logic [15:0]       ebi_data_out,
  input  logic              ebi_wr,
  input  logic              ebi_rd,
  input  logic              ebi_cs,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * NUM_CH);

  // Addresses below the base wrap to large offsets and fall out of range.
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-3:0] word;
  logic              in_range;
  reg_sel_e          reg_sel;

  assign off      = ebi_addr - BASE_ADDR;
  assign word     = off[ADDR_W-1:2];
  assign in_range = (off < SPAN);
  assign reg_sel  = reg_sel_e'(off[1:0]);

  // A strobe held over several cycles must write only once.
  logic wr_strobe;
  logic wr_strobe_prev_reg;
  logic wr_hit;

  assign wr_strobe = ebi_cs & ebi_wr;
  assign wr_hit    = wr_strobe & ~wr_strobe_prev_reg & in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_strobe_prev_reg <= 1'b0;
    else       wr_strobe_prev_reg <= wr_strobe;
  end

  logic [NUM_CH-1:0][CNT_W-1:0] stage_period;
  logic [NUM_CH-1:0][CNT_W-1:0] stage_duty;
  logic [NUM_CH-1:0][CNT_W-1:0] chan_count;
  logic [NUM_CH-1:0]            chan_en;
  logic [NUM_CH-1:0]            chan_inv;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic chan_hit;
      assign chan_hit = wr_hit & (word == (ADDR_W-2)'(gi));

      pwm_chan #(.CNT_W(CNT_W)) u_chan (
        .clk          (clk),
        .reset        (reset),
        .wr_period    (chan_hit & (reg_sel == REG_PERIOD)),
        .wr_duty      (chan_hit & (reg_sel == REG_DUTY)),
        .wr_ctrl      (chan_hit & (reg_sel == REG_CTRL)),
        .wr_data      (ebi_data_in[CNT_W-1:0]),
        .ctrl_bits    (ebi_data_in[2:0]),
        .period_stage (stage_period[gi]),
        .duty_stage   (stage_duty[gi]),
        .count        (chan_count[gi]),
        .enable       (chan_en[gi]),
        .invert       (chan_inv[gi]),
        .pwm          (pwm_out[gi])
      );
    end
  endgenerate

`ifdef PWM_READBACK_EN
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            rd_hit;
  logic [CH_W-1:0] rd_ch;
  logic [15:0]     rd_value;
  logic [15:0]     data_out_reg;
  logic            unused_bits;

  assign rd_hit      = ebi_cs & ebi_rd & in_range;
  assign rd_ch       = word[CH_W-1:0];
  assign unused_bits = ^ebi_data_in;

  always_comb begin
    rd_value = '0;
    if (rd_hit) begin
      case (reg_sel)
        REG_PERIOD: rd_value[CNT_W-1:0] = stage_period[rd_ch];
        REG_DUTY:   rd_value[CNT_W-1:0] = stage_duty[rd_ch];
        REG_CTRL: begin
          // Restart is a one-shot action, so it always reads back as 0.
          rd_value[CTRL_EN]  = chan_en[rd_ch];
          rd_value[CTRL_INV] = chan_inv[rd_ch];
        end
        default:    rd_value[CNT_W-1:0] = chan_count[rd_ch];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out_reg <= '0;
    else       data_out_reg <= rd_value;
  end

  assign ebi_data_out = data_out_reg;
`else
  logic unused_bits;
  assign unused_bits  = ^{ebi_rd, ebi_data_in, stage_period, stage_duty,
                          chan_count, chan_en, chan_inv};
  assign ebi_data_out = 16'h0000;
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table-driven single-channel patterns plus
// hand-written sequences (mid-period duty change, held write strobe,
// out-of-range writes, readback, reset mid-run). Expected pwm_out per cycle
// is pushed to a queue and compared by a monitor on every falling edge.
module tb_pwm_bank;
  import pwm_bank_pkg::*;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 21;
  localparam logic [ADDR_W-1:0] BASE = 21'h000100;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ebi_addr;
  logic [15:0]       ebi_data_in;
  logic [15:0]       ebi_data_out;
  logic              ebi_wr, ebi_rd, ebi_cs;
  logic [NUM_CH-1:0] pwm_out;

  pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ebi_addr(ebi_addr), .ebi_data_in(ebi_data_in),
    .ebi_data_out(ebi_data_out), .ebi_wr(ebi_wr), .ebi_rd(ebi_rd),
    .ebi_cs(ebi_cs), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [NUM_CH-1:0] exp_q[$];

  typedef struct {
    int ch;
    int period;
    int duty;
    bit inv;
    int n;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  // Scoreboard consumer: entry 0 of a push burst belongs to the falling edge
  // at which it was pushed.
  initial begin
    logic [NUM_CH-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwm_out", pwm_out, e);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] addr(input int ch, input int r);
    return BASE + ADDR_W'(4 * ch + r);
  endfunction

  // j = falling edges after the enabling write edge. The counter starts at 0
  // on the first edge after enable, and the pin lags the counter by one.
  function automatic logic pat(input int j, input int p, input int d, input bit inv);
    if (j == 0) return 1'b0;
    return (((j - 1) % (p + 1)) < d) ^ inv;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot_val(input int ch, input logic b);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[ch] = b;
    return v;
  endfunction

  task automatic ebi_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    @(negedge clk);
    ebi_addr = a; ebi_data_in = d; ebi_cs = 1'b1; ebi_wr = 1'b1;
    @(negedge clk);
    ebi_cs = 1'b0; ebi_wr = 1'b0;
  endtask

  // Returns the data one cycle after the strobe and the idle value after it.
  task automatic ebi_read(input logic [ADDR_W-1:0] a, output logic [15:0] d, output logic [15:0] idle);
    @(negedge clk);
    ebi_addr = a; ebi_cs = 1'b1; ebi_rd = 1'b1;
    @(negedge clk);
    ebi_cs = 1'b0; ebi_rd = 1'b0;
    #1 d = ebi_data_out;
    @(negedge clk);
    #1 idle = ebi_data_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic program_ch(input int ch, input int p, input int d);
    ebi_write(addr(ch, int'(REG_PERIOD)), 16'(p));
    ebi_write(addr(ch, int'(REG_DUTY)), 16'(d));
  endtask

  task automatic enable_ch(input int ch, input bit inv);
    ebi_write(addr(ch, int'(REG_CTRL)), inv ? 16'h0003 : 16'h0001);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam logic [15:0] RB_1234 =
`ifdef PWM_READBACK_EN
    16'h1234;
`else
    16'h0000;
`endif
  localparam logic [15:0] RB_0042 =
`ifdef PWM_READBACK_EN
    16'h0042;
`else
    16'h0000;
`endif
  localparam logic [15:0] RB_CTRL =
`ifdef PWM_READBACK_EN
    16'h0003;
`else
    16'h0000;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, idle;

    vecs[0] = '{ch: 0, period: 9, duty: 3,  inv: 1'b0, n: 25};
    vecs[1] = '{ch: 5, period: 9, duty: 0,  inv: 1'b0, n: 15};
    vecs[2] = '{ch: 6, period: 9, duty: 20, inv: 1'b0, n: 15};
    vecs[3] = '{ch: 7, period: 9, duty: 3,  inv: 1'b1, n: 25};
    vecs[4] = '{ch: 1, period: 0, duty: 1,  inv: 1'b0, n: 10};
    vecs[5] = '{ch: 3, period: 0, duty: 0,  inv: 1'b0, n: 10};
    vecs[6] = '{ch: 4, period: 4, duty: 2,  inv: 1'b0, n: 15};

    reset = 1'b1; ebi_addr = '0; ebi_data_in = '0;
    ebi_wr = 1'b0; ebi_rd = 1'b0; ebi_cs = 1'b0;
    #1;
    check("reset_pwm_out", pwm_out, 0);
    check("reset_data_out", ebi_data_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table-driven single-channel patterns.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      program_ch(vecs[v].ch, vecs[v].period, vecs[v].duty);
      enable_ch(vecs[v].ch, vecs[v].inv);
      for (int j = 0; j <= vecs[v].n; j++)
        exp_q.push_back(onehot_val(vecs[v].ch, pat(j, vecs[v].period, vecs[v].duty, vecs[v].inv)));
      wait_drain();
    end

    // ch2: duty 3 -> 7 mid-period, new duty starts exactly at the next wrap.
    do_reset();
    program_ch(2, 9, 3);
    enable_ch(2, 1'b0);
    for (int j = 0; j <= 35; j++)
      exp_q.push_back(onehot_val(2, pat(j, 9, (j <= 10) ? 3 : 7, 1'b0)));
    ebi_write(addr(2, int'(REG_DUTY)), 16'd7);
    wait_drain();

    // ch1: write strobe held for 4 edges with restart set -> one restart only.
    do_reset();
    program_ch(1, 9, 3);
    enable_ch(1, 1'b0);
    for (int j = 0; j <= 30; j++)
      exp_q.push_back(onehot_val(1, (j <= 5) ? pat(j, 9, 3, 1'b0)
                                             : logic'(((j - 6) % 10) < 3)));
    repeat (4) @(negedge clk);
    ebi_addr = addr(1, int'(REG_CTRL)); ebi_data_in = 16'h0005;
    ebi_cs = 1'b1; ebi_wr = 1'b1;
    repeat (4) @(negedge clk);
    ebi_cs = 1'b0; ebi_wr = 1'b0;
    wait_drain();

    // Out-of-range writes that would alias onto ch0 CTRL with a narrow decode.
    do_reset();
    program_ch(0, 9, 3);
    enable_ch(0, 1'b0);
    for (int j = 0; j <= 40; j++)
      exp_q.push_back(onehot_val(0, pat(j, 9, 3, 1'b0)));
    ebi_write(BASE + ADDR_W'(4 * NUM_CH + 2), 16'h0004);
    ebi_write(BASE - ADDR_W'(30), 16'h0000);
    ebi_write(BASE + ADDR_W'(4 * NUM_CH), 16'h0000);
    ebi_read(BASE + ADDR_W'(4 * NUM_CH), rd, idle);
    check("oob_read", rd, 0);
    wait_drain();

    // Register readback (all zero when the read path is not built).
    do_reset();
    ebi_write(addr(3, int'(REG_PERIOD)), 16'h1234);
    ebi_read(addr(3, int'(REG_PERIOD)), rd, idle);
    check("rd_period", rd, RB_1234);
    check("rd_idle", idle, 0);
    ebi_write(addr(3, int'(REG_DUTY)), 16'h0042);
    ebi_read(addr(3, int'(REG_DUTY)), rd, idle);
    check("rd_duty", rd, RB_0042);
    ebi_write(addr(3, int'(REG_CTRL)), 16'h0007);
    ebi_read(addr(3, int'(REG_CTRL)), rd, idle);
    check("rd_ctrl", rd, RB_CTRL);

    // Reset mid-run: pins drop at once, staging comes back cleared.
    do_reset();
    program_ch(0, 9, 3);
    enable_ch(0, 1'b0);
    repeat (2) @(negedge clk);
    #1 check("pre_reset_high", pwm_out, 1);
    #1 reset = 1'b1;
    #1 check("async_reset_pwm", pwm_out, 0);
    check("async_reset_data", ebi_data_out, 0);
    @(negedge clk);
    reset = 1'b0;
    ebi_read(addr(0, int'(REG_PERIOD)), rd, idle);
    check("rd_after_reset", rd, 0);
    enable_ch(0, 1'b0);
    for (int j = 0; j <= 15; j++)
      exp_q.push_back('0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Multi-channel successor to the single-channel pwm block.
- Holds NUM_CH independent PWM generators, each with its own programmable period, duty and control.
- Registers are written from the MCU over the EBI slave interface inside mecobo. Outputs drive the pwm_out pins.
- Period and duty updates are double-buffered and take effect only at period wrap, so outputs never glitch.

Parameters:
- NUM_CH, 8, number of PWM channels (1..16).
- CNT_W, 16, counter/period/duty width (1..16); EBI write data truncated to CNT_W LSBs.
- ADDR_W, 21, EBI address width.
- BASE_ADDR, 21'h000100, block base address; the block decodes addresses BASE_ADDR .. BASE_ADDR+4*NUM_CH-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- ebi_addr  in  ADDR_W  EBI word address
- ebi_data_in  in  16  EBI write data
- ebi_data_out  out  16  EBI read data
- ebi_wr  in  1  write strobe, active-high
- ebi_rd  in  1  read strobe, active-high
- ebi_cs  in  1  chip select, active-high
- pwm_out  out  NUM_CH  PWM outputs, bit i = channel i

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is asynchronous, active-high. It clears all registers, counters and shadows. pwm_out=0, ebi_data_out=0.
- Address map: off = ebi_addr - BASE_ADDR; ch = off[..:2]; reg = off[1:0].
  - reg 0: PERIOD
  - reg 1: DUTY
  - reg 2: CTRL (bit0 enable, bit1 invert, bit2 one-shot restart, self-clearing)
  - reg 3: COUNT (read-only; writes ignored)
  - ch >= NUM_CH or off outside range: no effect; reads return 0.
- Write:
  - hit = ebi_cs & ebi_wr & in-range.
  - Rising-edge detected: a strobe held N cycles writes exactly once, on its first clk edge.
  - The written value is visible in the staging register on the next cycle.
- Staging and shadowing:
  - PERIOD/DUTY writes go to staging registers.
  - Active copies load from staging when the counter wraps (count == active period), or immediately while the channel is disabled.
- Counter, per channel:
  - When enabled: count = 0..period, then wraps to 0.
  - When disabled: count held at 0.
  - A CTRL write with bit2=1 forces count=0 and loads the shadows on the next edge.
- Output:
  - raw = enable & (count < duty).
  - pwm_out = raw ^ (invert & enable), registered, so there is 1 cycle latency from count to pin.
  - A disabled channel outputs 0 regardless of invert.
- Boundaries:
  - duty=0 → raw always 0.
  - duty > period → raw always 1.
  - period=0 → count stuck at 0; raw = (duty != 0).
  - Write to PERIOD at the same edge as a wrap: the old staging value is loaded and the new value waits for the next wrap.
- Read:
  - Read strobe (ebi_cs & ebi_rd): ebi_data_out is registered and valid 1 cycle after the strobe.
  - ebi_data_out returns 0 when no read is active.
  - Values are zero-extended to 16 bits.
- Reset mid-period: all outputs drop to 0 asynchronously and all staging registers are cleared.

Optional Feature:
- Macro: PWM_READBACK_EN.
- Defined: the read path returns staging PERIOD, staging DUTY, CTRL (bit2 reads 0) and live COUNT.
- Undefined: ebi_data_out is tied to 16'h0000, the read mux is removed, and ebi_rd is unused.

Decomposition:
- Package pwm_bank_pkg holds:
  - register offset constants REG_PERIOD=0, REG_DUTY=1, REG_CTRL=2, REG_COUNT=3;
  - CTRL bit indices CTRL_EN=0, CTRL_INV=1, CTRL_RST=2.
- One sub-module, pwm_chan, instantiated NUM_CH times by a generate loop. It contains:
  - staging and active registers;
  - the counter;
  - the compare logic;
  - the output flop.
- pwm_bank itself contains the address decode, the write edge detect and the read mux.

Test Plan:
- Enable ch0 with period=9, duty=3 → pwm_out[0] high 3 cycles, low 7, repeating every 10 cycles; other bits stay 0.
- ch2 running period=9, duty=3; write duty=7 mid-period → current period keeps the 3/10 pattern; change to 7/10 starts exactly at the next wrap with no runt pulse.
- Hold ebi_cs&ebi_wr for 4 cycles to CTRL ch1 with restart=1 → count reset exactly once; only one write registered.
- duty=0 → output constant 0; duty=20 with period=9 → constant 1; invert=1 with duty=3, period=9 → 3 cycles low, 7 high.
- Write to ch index NUM_CH (off=4*NUM_CH) → no channel changes state; with PWM_READBACK_EN, read there returns 16'h0000.
- With PWM_READBACK_EN, write PERIOD ch3=16'h1234 then read → 16'h1234 one cycle after strobe. Assert reset mid-run → pwm_out=0 immediately and readback returns 0.
